// File: rtl/sw_leds_blink_pio_pkg.sv
// Shared constants for the LED blink PIO: register word addresses and
// STATUS/CTRL bit positions, plus the STATUS read-word packer.
package sw_leds_blink_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_BLINK  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;
  localparam logic [2:0] ADDR_COUNT  = 3'd7;

  localparam int STATUS_WRAP_BIT  = 0;
  localparam int STATUS_PHASE_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT  = 0;

  function automatic logic [31:0] status_word(input logic wrap_flag, input logic phase);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[STATUS_WRAP_BIT]  = wrap_flag;
    w[STATUS_PHASE_BIT] = phase;
    return w;
  endfunction

endpackage

// File: rtl/sw_leds_blink_pio_blink_prescaler.sv
// Square-wave phase generator: counts 0..period-1, toggles phase and pulses
// wrap on the terminal count; period == 0 freezes the engine.
module blink_prescaler #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] period,
  input  logic                restart,
  output logic                phase,
  output logic                wrap,
  output logic [PERIOD_W-1:0] count
);

  localparam logic [PERIOD_W-1:0] CNT_ZERO = {PERIOD_W{1'b0}};
  localparam logic [PERIOD_W-1:0] CNT_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};

  logic [PERIOD_W-1:0] count_q, count_d;
  logic                phase_q, phase_d;
  logic                wrap_s;

  // Next counter/phase; a restart (PERIOD write) suppresses the wrap pulse
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    wrap_s  = 1'b0;
    if (restart) begin
      count_d = CNT_ZERO;
      phase_d = 1'b0;
    end else if (period == CNT_ZERO) begin
      count_d = CNT_ZERO;
      phase_d = phase_q;
    end else if (count_q == (period - CNT_ONE)) begin
      count_d = CNT_ZERO;
      phase_d = ~phase_q;
      wrap_s  = 1'b1;
    end else begin
      count_d = count_q + CNT_ONE;
      phase_d = phase_q;
    end
  end

  // Counter and phase state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= CNT_ZERO;
      phase_q <= 1'b0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;
  assign wrap  = wrap_s;
  assign count = count_q;

endmodule

// File: rtl/sw_leds_blink_pio.sv
// Avalon-MM LED output PIO with set/clear aliases, per-bit blink mask and a
// phase-wrap interrupt for pacing software animations.
module sw_leds_blink_pio
  import sw_leds_blink_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 10,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}},
  parameter int                    PERIOD_W    = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  logic                  wr_s;
  logic [DATA_WIDTH-1:0] wd_s;
  logic                  restart_s;
  logic                  phase_s;
  logic                  wrap_s;
  logic [PERIOD_W-1:0]   count_s;
  logic                  unused_s;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] blink_q, blink_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic                  irq_en_q, irq_en_d;
  logic                  wrap_flag_q, wrap_flag_d;
  logic [31:0]           readdata_q, readdata_d;
  logic [DATA_WIDTH-1:0] out_port_q, out_port_d;

  assign wr_s      = chipselect & ~write_n;
  assign wd_s      = writedata[DATA_WIDTH-1:0];
  assign restart_s = wr_s && (address == ADDR_PERIOD);
  assign unused_s  = &{1'b0, writedata};

  blink_prescaler #(
    .PERIOD_W (PERIOD_W)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .period  (period_q),
    .restart (restart_s),
    .phase   (phase_s),
    .wrap    (wrap_s),
    .count   (count_s)
  );

  // Register writes; OUTSET/OUTCLR are read-modify-write of the latch
  always_comb begin
    data_d   = data_q;
    blink_d  = blink_q;
    period_d = period_q;
    irq_en_d = irq_en_q;
    if (wr_s) begin
      case (address)
        ADDR_DATA:   data_d   = wd_s;
        ADDR_BLINK:  blink_d  = wd_s;
        ADDR_PERIOD: period_d = writedata[PERIOD_W-1:0];
        ADDR_CTRL:   irq_en_d = writedata[CTRL_IRQ_EN_BIT];
        ADDR_OUTSET: data_d   = data_q | wd_s;
        ADDR_OUTCLR: data_d   = data_q & ~wd_s;
        default:     data_d   = data_q;
      endcase
    end else begin
      data_d = data_q;
    end
  end

  // Sticky wrap flag; a wrap in the same cycle as a W1C keeps it set
  always_comb begin
    wrap_flag_d = wrap_flag_q;
    if (wrap_s) begin
      wrap_flag_d = 1'b1;
    end else if (wr_s && (address == ADDR_STATUS) && writedata[STATUS_WRAP_BIT]) begin
      wrap_flag_d = 1'b0;
    end else begin
      wrap_flag_d = wrap_flag_q;
    end
  end

  // Read mux, sampled every cycle independent of chipselect
  always_comb begin
    readdata_d = 32'h0000_0000;
    case (address)
      ADDR_DATA:   readdata_d = 32'(data_q);
      ADDR_BLINK:  readdata_d = 32'(blink_q);
      ADDR_PERIOD: readdata_d = 32'(period_q);
      ADDR_CTRL:   readdata_d = 32'(irq_en_q);
      ADDR_STATUS: readdata_d = status_word(wrap_flag_q, phase_s);
      ADDR_COUNT:  readdata_d = 32'(count_s);
      default:     readdata_d = 32'h0000_0000;
    endcase
  end

  assign out_port_d = data_q ^ (blink_q & {DATA_WIDTH{phase_s}});

  // Register file and output flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q      <= RESET_VALUE;
      blink_q     <= {DATA_WIDTH{1'b0}};
      period_q    <= {PERIOD_W{1'b0}};
      irq_en_q    <= 1'b0;
      wrap_flag_q <= 1'b0;
      readdata_q  <= 32'h0000_0000;
      out_port_q  <= RESET_VALUE;
    end else begin
      data_q      <= data_d;
      blink_q     <= blink_d;
      period_q    <= period_d;
      irq_en_q    <= irq_en_d;
      wrap_flag_q <= wrap_flag_d;
      readdata_q  <= readdata_d;
      out_port_q  <= out_port_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = out_port_q;
  assign irq      = wrap_flag_q & irq_en_q;

endmodule
